// File: rtl/wb_machine_timer_pkg.sv
// Shared definitions for the Wishbone machine timer: register indices and a
// byte-lane merge helper used by Wishbone peripherals.
package wb_machine_timer_pkg;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MSIP        = 3'd4;

  function automatic logic [31:0] wb_merge_bytes(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wb_prescaler.sv
// Free-running divide-by-PRESCALE counter; tick_o is high for one cycle in
// every PRESCALE cycles, on the cycle the counter holds PRESCALE-1.
module wb_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) and software-interrupt register as a
// Wishbone pipelined slave with single-cycle registered responses.
module wb_machine_timer
  import wb_machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        mtip_o,
  output logic        msip_o
);

  logic        tick;
  logic [2:0]  idx;
  logic        acc, bad, wr, rd;
  logic [31:0] rdata;
  logic [63:0] mtime_inc;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  // Upper address bits are decoded by the interconnect.
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[31:5];

  wb_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  assign idx = wb_adr_i[4:2];

  always_comb begin
    acc = wb_cyc_i & wb_stb_i;
    bad = (idx > MSIP) | (wb_adr_i[1:0] != 2'b00);
    wr  = acc & ~bad & wb_we_i;
    rd  = acc & ~bad & ~wb_we_i;

    rdata = '0;
    case (idx)
      MTIME_LO:    rdata = mtime_q[31:0];
      MTIME_HI:    rdata = mtime_q[63:32];
      MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      MSIP:        rdata = {31'd0, msip_q};
      default:     rdata = '0;
    endcase

    // A write in a tick cycle overrides only its selected bytes of the
    // already-incremented value, so the carry comes from the pre-write value.
    mtime_inc  = mtime_q + 64'(tick);
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (idx)
        MTIME_LO:    mtime_d[31:0]     = wb_merge_bytes(mtime_inc[31:0],    wb_dat_i, wb_sel_i);
        MTIME_HI:    mtime_d[63:32]    = wb_merge_bytes(mtime_inc[63:32],   wb_dat_i, wb_sel_i);
        MTIMECMP_LO: mtimecmp_d[31:0]  = wb_merge_bytes(mtimecmp_q[31:0],  wb_dat_i, wb_sel_i);
        MTIMECMP_HI: mtimecmp_d[63:32] = wb_merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        MSIP:        if (wb_sel_i[0]) msip_d = wb_dat_i[0];
        default:     ;
      endcase
    end

    ack_d  = acc & ~bad;
    err_d  = acc & bad;
    dat_d  = rd ? rdata : '0;
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign mtip_o     = mtip_q;
  assign msip_o     = msip_q;

endmodule

// File: tb/tb_wb_machine_timer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share one bus; a behavioural
// model predicts responses and interrupt lines, a monitor compares each cycle.
module tb_wb_machine_timer;

  typedef struct {
    int unsigned     due;
    bit              ack;
    bit              err;
    logic [1:0][31:0] d;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;

  logic [1:0]       stall, ack, err, mtip, msip;
  logic [1:0][31:0] dat;

  int checks = 0;
  int failures = 0;
  int unsigned tcyc = 0;
  int unsigned k = 0;
  int unsigned P[2] = '{1, 4};
  logic [63:0] mt[2], cmp[2];
  bit msip_m[2], mtip_m[2];
  exp_t q[$];

  wb_machine_timer #(.PRESCALE(1)) u_p1 (
    .clk_i(clk_i), .reset_i(reset_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_stall_o(stall[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_dat_o(dat[0]),
    .mtip_o(mtip[0]), .msip_o(msip[0]));

  wb_machine_timer #(.PRESCALE(4)) u_p4 (
    .clk_i(clk_i), .reset_i(reset_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_stall_o(stall[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_dat_o(dat[1]),
    .mtip_o(mtip[1]), .msip_o(msip[1]));

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = 64'd0; cmp[i] = '1; msip_m[i] = 1'b0; mtip_m[i] = 1'b0;
    end
    k = 0;
    q.delete();
  endtask

  function automatic logic [31:0] model_read(input int i, input logic [2:0] idx);
    case (idx)
      3'd0: return mt[i][31:0];
      3'd1: return mt[i][63:32];
      3'd2: return cmp[i][31:0];
      3'd3: return cmp[i][63:32];
      3'd4: return {31'd0, msip_m[i]};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, predict, commit the model at the edge.
  task automatic bus(input bit c, input bit s, input bit we, input logic [31:0] adr,
                     input logic [31:0] wdat, input logic [3:0] sel);
    exp_t e;
    logic [63:0] nmt[2], ncmp[2];
    bit nms[2], nip[2];
    logic [2:0] idx;
    bit bad, acc;
    @(negedge clk_i);
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel;
    idx = adr[4:2];
    bad = (idx > 3'd4) || (adr[1:0] != 2'b00);
    acc = c && s;
    e.due = tcyc + 1;
    e.ack = acc && !bad;
    e.err = acc && bad;
    for (int i = 0; i < 2; i++) begin
      e.d[i]  = (acc && !bad && !we) ? model_read(i, idx) : 32'd0;
      nmt[i]  = mt[i] + (((k % P[i]) == P[i] - 1) ? 64'd1 : 64'd0);
      ncmp[i] = cmp[i];
      nms[i]  = msip_m[i];
      nip[i]  = (mt[i] >= cmp[i]);
      if (acc && !bad && we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) begin
          case (idx)
            3'd0: nmt[i][8*b +: 8]       = wdat[8*b +: 8];
            3'd1: nmt[i][32 + 8*b +: 8]  = wdat[8*b +: 8];
            3'd2: ncmp[i][8*b +: 8]      = wdat[8*b +: 8];
            3'd3: ncmp[i][32 + 8*b +: 8] = wdat[8*b +: 8];
            default: ;
          endcase
        end
        if (idx == 3'd4 && sel[0]) nms[i] = wdat[0];
      end
    end
    if (acc) q.push_back(e);
    @(posedge clk_i);
    for (int i = 0; i < 2; i++) begin
      mt[i] = nmt[i]; cmp[i] = ncmp[i]; msip_m[i] = nms[i]; mtip_m[i] = nip[i];
    end
    k++;
  endtask

  task automatic rd(input logic [31:0] adr);
    bus(1, 1, 0, adr, $urandom, 4'($urandom));
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    bus(1, 1, 1, adr, d, sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(0, 0, 0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #2;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    reset_i = 1'b1;
  endtask

  // Monitor: response timing/content plus interrupt lines every cycle.
  initial begin
    exp_t e;
    bit r, want;
    forever begin
      @(posedge clk_i);
      tcyc++;
      #1;
      r = (ack != 2'b00) || (err != 2'b00);
      want = (q.size() > 0) && (q[0].due == tcyc);
      chk("resp_timing", 64'(r), 64'(want));
      if (want) begin
        e = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("ack[%0d]", i), 64'(ack[i]), 64'(e.ack));
          chk($sformatf("err[%0d]", i), 64'(err[i]), 64'(e.err));
          chk($sformatf("rdata[%0d]", i), 64'(dat[i]), 64'(e.d[i]));
        end
      end else begin
        for (int i = 0; i < 2; i++) chk($sformatf("idle_dat[%0d]", i), 64'(dat[i]), 64'd0);
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall[%0d]", i), 64'(stall[i]), 64'd0);
        chk($sformatf("mtip[%0d]", i), 64'(mtip[i]), 64'(mtip_m[i]));
        chk($sformatf("msip[%0d]", i), 64'(msip[i]), 64'(msip_m[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    model_reset();
    #1 reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    release_reset();

    // Reset values of mtimecmp
    rd(32'h08); rd(32'h0C);

    // Low-to-high carry
    wr(32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    idle(3);
    rd(32'h04); rd(32'h00);

    // Timer interrupt rise and glitch-free clear
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h08, 32'h10, 4'hF);
    wr(32'h0C, 32'h0, 4'hF);
    idle(25);
    wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF);
    idle(3);

    // Software interrupt with byte enables
    wr(32'h10, 32'h1, 4'b0001);
    wr(32'h10, 32'h0, 4'b0000);
    idle(2);
    rd(32'h10);
    wr(32'h10, 32'hFFFF_FFFE, 4'b1111);

    // Error accesses change nothing
    rd(32'h18); wr(32'h18, 32'h1234_5678, 4'hF);
    rd(32'h02); wr(32'h02, 32'hDEAD_BEEF, 4'hF);
    wr(32'h1C, 32'h0, 4'hF); wr(32'h11, 32'h1, 4'h1);
    // Four back-to-back reads
    rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C);
    bus(0, 1, 0, 32'h00, 32'h0, 4'h0);
    bus(1, 0, 1, 32'h00, 32'h0, 4'hF);

    // Byte write in a tick cycle for PRESCALE=4
    while ((k % 4) != 2) idle(1);
    wr(32'h00, 32'h0000_01FF, 4'hF);
    wr(32'h00, 32'h0000_00AA, 4'b0001);
    rd(32'h00);
    #1 chk("p4_tick_byte_write", 64'(dat[1]), 64'h0000_02AA);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      a = {r[31:5], 3'($urandom_range(0, 7)), (r[4:0] == 5'd0) ? r[6:5] : 2'b00};
      bus(($urandom % 8) != 0, ($urandom % 5) != 0, r[7], a, $urandom, 4'($urandom));
    end
    idle(2);

    // Reset asserted while a read is on the bus
    @(negedge clk_i);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h0;
    #2 reset_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ack[%0d]", i), 64'(ack[i]), 64'd0);
      chk($sformatf("rst_dat[%0d]", i), 64'(dat[i]), 64'd0);
    end
    release_reset();
    rd(32'h00); rd(32'h04); rd(32'h10);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
